// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB stepping, memory handshakes,
// write strobes for IR/RF/PC, cycle and instret counters, and a sticky memory-timeout error.
module riscv_mc_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  output logic             imem_req_o,
  input  logic             imem_ready_i,
  output logic             ir_we_o,
  input  logic             rd_we_i,
  input  logic             data_re_i,
  input  logic             data_we_i,
  input  logic             br_i,
  input  logic             br_taken_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ready_i,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic             retire_o,
  output logic             err_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StErr    = 3'd6;

  localparam int unsigned WaitW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitLim = WaitW'(WAIT_MAX);

  logic [2:0]       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             wait_hit;

  // A zero limit disables the timeout altogether.
  assign wait_hit = (WAIT_MAX != 0) && (wait_q == WaitLim);

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready_i) begin
          state_d = StDecode;
        end else if (wait_hit) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        state_d = (data_re_i | data_we_i) ? StMem : StWb;
      end
      StMem: begin
        if (dmem_ready_i) begin
          state_d = StWb;
        end else if (wait_hit) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        state_d = run_i ? StFetch : StIdle;
      end
      StErr: state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q != StIdle && state_q != StErr) cycle_q <= cycle_q + 1'b1;
      if (state_q == StWb) instret_q <= instret_q + 1'b1;
    end
  end

  // Strobes are pure decodes of state, squashed while reset is held.
  always_comb begin
    imem_req_o = ~rst & (state_q == StFetch);
    ir_we_o    = ~rst & (state_q == StFetch) & imem_ready_i;
    dmem_req_o = ~rst & (state_q == StMem);
    dmem_we_o  = ~rst & (state_q == StMem) & data_we_i;
    rf_we_o    = ~rst & (state_q == StWb) & rd_we_i;
    pc_we_o    = ~rst & (state_q == StWb);
    retire_o   = ~rst & (state_q == StWb);
    pc_sel_o   = (state_q == StWb) & br_i & br_taken_i;
  end

  assign err_o       = (state_q == StErr);
  assign state_o     = state_q;
  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and runs the valid/ready handshakes to the instruction and data memories. It drives the write strobes for the IR, register file and PC from the decoder's control flags (`rd_we`, `data_re`, `data_we`, `br`) and the ALU branch-compare result. It also keeps cycle and retired-instruction counters and a sticky memory-timeout error.

## Interface
Parameters:
- `WAIT_MAX`, default 15. Maximum ready-low cycles tolerated in FETCH or MEM. A value of 0 disables the timeout.
- `CNT_W`, default 32. Width of the cycle and instret counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run_i` in 1: enables instruction issue.
- `imem_req_o` out 1: instruction-fetch request.
- `imem_ready_i` in 1: instruction word valid this cycle.
- `ir_we_o` out 1: latch the instruction word into the IR.
- `rd_we_i`, `data_re_i`, `data_we_i`, `br_i` in 1 each: decoder flags for the instruction in IR.
- `br_taken_i` in 1: ALU compare result (zero/`zero_en` logic already resolved outside this block).
- `dmem_req_o` out 1: data-memory request.
- `dmem_we_o` out 1: data-memory write (store) when `dmem_req_o` is high.
- `dmem_ready_i` in 1: data access complete this cycle.
- `rf_we_o` out 1: register-file write strobe.
- `pc_we_o` out 1: PC update strobe.
- `pc_sel_o` out 1: 0 selects pc+4, 1 selects pc+offset.
- `retire_o` out 1: one-cycle pulse per completed instruction.
- `err_o` out 1: sticky timeout error.
- `state_o` out 3: current state encoding.
- `cycle_cnt_o` out `CNT_W`: active-cycle counter.
- `instret_o` out `CNT_W`: retired-instruction counter.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6. Encoding 7 is unreachable and recovers to IDLE.
- **IDLE**
  - All strobes are 0.
  - `run_i`=1 moves to FETCH.
- **FETCH**
  - `imem_req_o`=1 and is held until ready.
  - When `imem_ready_i`=1: `ir_we_o`=1 in that same cycle, then move to DECODE.
- **DECODE**
  - Exactly one cycle (operand settle), then move to EXEC.
- **EXEC**
  - Exactly one cycle.
  - `data_re_i|data_we_i` moves to MEM; otherwise move to WB.
- **MEM**
  - `dmem_req_o`=1 and `dmem_we_o`=`data_we_i`, both held until `dmem_ready_i`.
  - When `dmem_ready_i`=1, move to WB.
- **WB**
  - Exactly one cycle.
  - `rf_we_o`=`rd_we_i`.
  - `pc_we_o`=1.
  - `pc_sel_o`=`br_i & br_taken_i`.
  - `retire_o`=1 and `instret_o` increments.
  - Next state: `run_i` ? FETCH : IDLE.
- **ERR**
  - All strobes are 0 and `err_o`=1.
  - Only `rst` exits ERR.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle spent in FETCH or MEM with ready low.
  - If ready is low and the counter equals `WAIT_MAX` (with `WAIT_MAX`≠0), move to ERR.
  - A ready arriving on the limit cycle is accepted normally. A state may therefore last up to `WAIT_MAX`+1 cycles.
  - The counter is sized to hold `WAIT_MAX` without wrap.
- Counters:
  - `cycle_cnt_o` increments every cycle the state is not IDLE or ERR.
  - Both counters wrap modulo 2^`CNT_W` without flagging.
- `run_i` is sampled only in IDLE and WB. Deasserting it mid-instruction still completes that instruction.
- Unused strobes are 0 in every state not listed against them.

## Timing
- Reset values:
  - State IDLE.
  - `cycle_cnt_o`=0, `instret_o`=0, `err_o`=0.
  - All strobes 0; `state_o`=0.
- While `rst`=1, all strobe outputs (`imem_req_o`, `ir_we_o`, `dmem_req_o`, `dmem_we_o`, `rf_we_o`, `pc_we_o`, `retire_o`) are forced to 0 combinationally, in any state. Reset mid-instruction discards that instruction, and the next cycle starts in IDLE.
- Strobes are combinational decodes of state plus the listed inputs; they carry no extra register stage.
- Latency with zero-wait memories (ready high on the first request cycle):
  - ALU or branch instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles (FETCH, DECODE, EXEC, MEM, WB).
  - Each wait cycle adds 1.
- Back-to-back issue: WB is followed directly by FETCH with no bubble when `run_i`=1.
- `imem_ready_i` outside FETCH and `dmem_ready_i` outside MEM are ignored.

## Test plan
- **Reset, then issue one instruction.** Reset, then `run_i`=1 with an ADD (`rd_we_i`=1, all other flags 0) and ready always 1.
  - States go 0→1→2→3→5→1.
  - `ir_we_o` pulses in FETCH; `rf_we_o`, `pc_we_o` and `retire_o` pulse in WB with `pc_sel_o`=0.
  - `instret_o`=1 and `cycle_cnt_o`=4 after WB.
- **Store with data-memory wait.** `data_we_i`=1, `rd_we_i`=0, `dmem_ready_i` low for 3 cycles in MEM.
  - `dmem_req_o` and `dmem_we_o` are high for 4 cycles.
  - `rf_we_o`=0 in WB; the instruction takes 8 cycles in total.
- **Branch resolution.** `br_i`=1: with `br_taken_i`=1, WB shows `pc_sel_o`=1 and `rf_we_o`=0; with `br_taken_i`=0, WB shows `pc_sel_o`=0.
- **Fetch timeout boundary** (`WAIT_MAX`=15).
  - `imem_ready_i` held low: ERR (`state_o`=6, `err_o`=1) after 16 FETCH cycles, and ERR holds through further `run_i` and ready activity.
  - Ready asserted on the 16th FETCH cycle instead: normal move to DECODE.
- **Reset mid-operation.** `rst` asserted in MEM while `dmem_req_o`=1.
  - `dmem_req_o` drops in the same cycle.
  - Next cycle: `state_o`=0 and counters 0.
  - A reset asserted while in ERR clears `err_o`.
- **Stop after the current instruction.** `run_i` deasserted during EXEC.
  - The instruction completes WB, then the block enters IDLE.
  - `cycle_cnt_o` is frozen while idle.
